// File: rtl/ifm_window_buf.sv
// K x K sliding IFM window register for a convolution PE array.
// Op beats shift a new line in from any edge; each shift after fill presents a new window.
module ifm_window_buf #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [K*DATA_W-1:0]        in_data,
    input  logic                       pad_en,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [K*K*DATA_W-1:0]      win_data,
    output logic [CNT_W-1:0]           win_cnt
);

    localparam int FILL_W = $clog2(K + 1);

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_RIGHT = 3'b001,
        OP_DOWN  = 3'b010,
        OP_UP    = 3'b011,
        OP_LEFT  = 3'b100,
        OP_CLEAR = 3'b111
    } op_e;

    logic signed [DATA_W-1:0] win_q [K][K];
    logic signed [DATA_W-1:0] win_d [K][K];
    logic signed [DATA_W-1:0] line  [K];
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     valid_q, valid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    op_e  op;
    logic accept;
    logic consume;
    logic clear_fire;
    logic shift_acc;

    assign op       = op_e'(in_op);
    assign in_ready = !valid_q || win_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && win_ready;
    // CLEAR is a flush: it must not wait behind a stalled window.
    assign clear_fire = in_valid && (op == OP_CLEAR);

    always_comb begin
        for (int j = 0; j < K; j++) begin
            line[j] = pad_en ? '0 : in_data[j*DATA_W +: DATA_W];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win_d     = win_q;
        fill_d    = fill_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        shift_acc = 1'b0;

        if (consume) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end

        if (accept) begin
            case (op)
                OP_RIGHT: begin
                    shift_acc = 1'b1;
                    for (int r = 0; r < K; r++) begin
                        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
                        win_d[r][K-1] = line[r];
                    end
                end
                OP_LEFT: begin
                    shift_acc = 1'b1;
                    for (int r = 0; r < K; r++) begin
                        for (int c = 1; c < K; c++) win_d[r][c] = win_q[r][c-1];
                        win_d[r][0] = line[r];
                    end
                end
                OP_DOWN: begin
                    shift_acc = 1'b1;
                    for (int c = 0; c < K; c++) begin
                        for (int r = 0; r < K - 1; r++) win_d[r][c] = win_q[r+1][c];
                        win_d[K-1][c] = line[c];
                    end
                end
                OP_UP: begin
                    shift_acc = 1'b1;
                    for (int c = 0; c < K; c++) begin
                        for (int r = 1; r < K; r++) win_d[r][c] = win_q[r-1][c];
                        win_d[0][c] = line[c];
                    end
                end
                default: ;
            endcase
        end

        if (shift_acc) begin
            fill_d = (fill_q == FILL_W'(K)) ? fill_q : fill_q + FILL_W'(1);
            if (fill_d == FILL_W'(K)) valid_d = 1'b1;
        end

        if (clear_fire) begin
            win_d   = '{default: '0};
            fill_d  = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    // NOTE: the window is a flop array rather than a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '{default: '0};
            fill_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            assign win_data[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
        end
    end

    assign win_valid = valid_q;
    assign win_cnt   = cnt_q;

endmodule

// File: tb/tb_ifm_window_buf.sv
// Directed bench for ifm_window_buf (K=3, DATA_W=8, CNT_W=2): consumed windows go
// through a scoreboard queue, state after each beat is checked inline.
module tb_ifm_window_buf;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int CW = 2;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_RIGHT = 3'b001;
    localparam logic [2:0] OP_DOWN  = 3'b010;
    localparam logic [2:0] OP_UP    = 3'b011;
    localparam logic [2:0] OP_LEFT  = 3'b100;
    localparam logic [2:0] OP_BAD   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [K*DW-1:0]      in_data;
    logic                 pad_en;
    logic                 win_valid;
    logic                 win_ready;
    logic [K*K*DW-1:0]    win_data;
    logic [CW-1:0]        win_cnt;

    typedef struct {
        logic [K*K*DW-1:0] data;
        logic [CW-1:0]     cnt;
        string             tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    ifm_window_buf #(.DATA_W(DW), .K(K), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .pad_en    (pad_en),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [K*DW-1:0] p3(input int a, input int b, input int c);
        logic [7:0] ea, eb, ec;
        ea = a[7:0]; eb = b[7:0]; ec = c[7:0];
        return {ec, eb, ea};
    endfunction

    // Arguments in row-major order: (0,0) (0,1) (0,2) (1,0) ... (2,2).
    function automatic logic [K*K*DW-1:0] w9(input int a, input int b, input int c,
                                             input int d, input int e, input int f,
                                             input int g, input int h, input int i);
        return {p3(g, h, i), p3(d, e, f), p3(a, b, c)};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [K*K*DW-1:0] d, input logic [CW-1:0] c, input string tag);
        exp_t e;
        e.data = d; e.cnt = c; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [2:0] op, input logic [K*DW-1:0] d,
                        input logic pad, input logic wr);
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        pad_en    = pad;
        win_ready = wr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_op     = OP_NOP;
        pad_en    = 1'b0;
        win_ready = 1'b0;
    endtask

    task automatic idle(input logic wr);
        in_valid  = 1'b0;
        win_ready = wr;
        @(posedge clk);
        #1;
        win_ready = 1'b0;
    endtask

    // Monitor: every handshake on the window port pops one expected window.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && win_valid === 1'b1 && win_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL consume_unexpected: got data %h cnt %0d expected no consume",
                         win_data, win_cnt);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_data"}, 72'(win_data), 72'(mon_e.data));
                check({mon_e.tag, "_cnt"},  72'(win_cnt),  72'(mon_e.cnt));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_NOP;
        in_data   = '0;
        pad_en    = 1'b0;
        win_ready = 1'b0;
        #12;
        check("rst_valid", 72'(win_valid), 72'(0));
        check("rst_ready", 72'(in_ready),  72'(1));
        check("rst_cnt",   72'(win_cnt),   72'(0));
        check("rst_data",  72'(win_data),  72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with three DOWN rows while the PE array stalls.
        beat(OP_DOWN, p3(1, 2, 3), 1'b0, 1'b0);
        check("fill1_valid", 72'(win_valid), 72'(0));
        beat(OP_DOWN, p3(4, 5, 6), 1'b0, 1'b0);
        check("fill2_valid", 72'(win_valid), 72'(0));
        beat(OP_DOWN, p3(7, 8, 9), 1'b0, 1'b0);
        check("fill3_valid", 72'(win_valid), 72'(1));
        check("fill3_ready", 72'(in_ready),  72'(0));
        check("fill3_data",  72'(win_data),  72'(w9(1, 2, 3, 4, 5, 6, 7, 8, 9)));

        // Stalled beat is not accepted; window holds.
        beat(OP_RIGHT, p3(99, 98, 97), 1'b0, 1'b0);
        check("stall_data",  72'(win_data),  72'(w9(1, 2, 3, 4, 5, 6, 7, 8, 9)));
        check("stall_valid", 72'(win_valid), 72'(1));

        push(w9(1, 2, 3, 4, 5, 6, 7, 8, 9), 2'd0, "cons_w1");
        beat(OP_RIGHT, p3(10, 11, 12), 1'b0, 1'b1);
        check("slide_data",  72'(win_data),  72'(w9(2, 3, 10, 5, 6, 11, 8, 9, 12)));
        check("slide_valid", 72'(win_valid), 72'(1));
        check("slide_cnt",   72'(win_cnt),   72'(1));

        push(w9(2, 3, 10, 5, 6, 11, 8, 9, 12), 2'd1, "cons_w2");
        beat(OP_LEFT, p3(55, 66, 77), 1'b1, 1'b1);
        check("pad_data", 72'(win_data), 72'(w9(0, 2, 3, 0, 5, 6, 0, 8, 9)));
        check("pad_cnt",  72'(win_cnt),  72'(2));

        push(w9(0, 2, 3, 0, 5, 6, 0, 8, 9), 2'd2, "cons_w3");
        beat(OP_UP, p3(20, 21, 22), 1'b0, 1'b1);
        check("up_data", 72'(win_data), 72'(w9(20, 21, 22, 0, 2, 3, 0, 5, 6)));
        check("up_cnt",  72'(win_cnt),  72'(3));

        // CLEAR while stalled.
        beat(OP_CLEAR, p3(5, 5, 5), 1'b0, 1'b0);
        check("clr_data",  72'(win_data),  72'(0));
        check("clr_valid", 72'(win_valid), 72'(0));
        check("clr_cnt",   72'(win_cnt),   72'(0));
        beat(OP_RIGHT, p3(1, 2, 3), 1'b0, 1'b0);
        check("refill1_valid", 72'(win_valid), 72'(0));
        check("refill1_data",  72'(win_data),  72'(w9(0, 0, 1, 0, 0, 2, 0, 0, 3)));
        beat(OP_RIGHT, p3(4, 5, 6), 1'b0, 1'b0);
        check("refill2_valid", 72'(win_valid), 72'(0));
        beat(OP_RIGHT, p3(7, 8, 9), 1'b0, 1'b0);
        check("refill3_valid", 72'(win_valid), 72'(1));
        check("refill3_data",  72'(win_data),  72'(w9(1, 4, 7, 2, 5, 8, 3, 6, 9)));

        // Undefined op behaves as NOP and consumes.
        push(w9(1, 4, 7, 2, 5, 8, 3, 6, 9), 2'd0, "cons_w4");
        beat(OP_BAD, p3(33, 33, 33), 1'b0, 1'b1);
        check("badop_data",  72'(win_data),  72'(w9(1, 4, 7, 2, 5, 8, 3, 6, 9)));
        check("badop_valid", 72'(win_valid), 72'(0));
        check("badop_cnt",   72'(win_cnt),   72'(1));

        beat(OP_DOWN, p3(10, 20, 30), 1'b0, 1'b1);
        check("d1_valid", 72'(win_valid), 72'(1));
        check("d1_cnt",   72'(win_cnt),   72'(1));
        check("d1_data",  72'(win_data),  72'(w9(2, 5, 8, 3, 6, 9, 10, 20, 30)));

        push(w9(2, 5, 8, 3, 6, 9, 10, 20, 30), 2'd1, "cons_w5");
        beat(OP_DOWN, p3(40, 50, 60), 1'b0, 1'b1);
        check("d2_data", 72'(win_data), 72'(w9(3, 6, 9, 10, 20, 30, 40, 50, 60)));
        check("d2_cnt",  72'(win_cnt),  72'(2));

        push(w9(3, 6, 9, 10, 20, 30, 40, 50, 60), 2'd2, "cons_w6");
        beat(OP_NOP, p3(1, 1, 1), 1'b0, 1'b1);
        check("nop_valid", 72'(win_valid), 72'(0));
        check("nop_cnt",   72'(win_cnt),   72'(3));
        check("nop_data",  72'(win_data),  72'(w9(3, 6, 9, 10, 20, 30, 40, 50, 60)));

        beat(OP_UP, p3(7, 7, 7), 1'b0, 1'b1);
        check("u2_data", 72'(win_data), 72'(w9(7, 7, 7, 3, 6, 9, 10, 20, 30)));

        push(w9(7, 7, 7, 3, 6, 9, 10, 20, 30), 2'd3, "cons_w7");
        idle(1'b1);
        check("wrap_cnt",   72'(win_cnt),   72'(0));
        check("wrap_valid", 72'(win_valid), 72'(0));

        beat(OP_RIGHT, p3(1, 2, 3), 1'b0, 1'b1);
        check("r3_data", 72'(win_data), 72'(w9(7, 7, 1, 6, 9, 2, 20, 30, 3)));
        push(w9(7, 7, 1, 6, 9, 2, 20, 30, 3), 2'd0, "cons_w8");
        idle(1'b1);
        check("post_wrap_cnt", 72'(win_cnt), 72'(1));
        beat(OP_RIGHT, p3(4, 5, 6), 1'b0, 1'b0);
        check("pre_rst_valid", 72'(win_valid), 72'(1));

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 72'(win_valid), 72'(0));
        check("arst_data",  72'(win_data),  72'(0));
        check("arst_cnt",   72'(win_cnt),   72'(0));
        check("arst_ready", 72'(in_ready),  72'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(OP_DOWN, p3(9, 9, 9), 1'b0, 1'b0);
        check("post_rst_valid", 72'(win_valid), 72'(0));
        check("post_rst_data",  72'(win_data),  72'(w9(0, 0, 0, 0, 0, 0, 9, 9, 9)));

        repeat (2) @(posedge clk);
        check("sb_drained", 72'(sb.size()), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifm_window_buf.md
IFM_WINDOW_BUF -- requirements
Module: ifm_window_buf

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning the signed width of one IFM element.
REQ-002 The block SHALL expose parameter K, default 3, range 2..7, meaning the window edge; the window holds K*K elements.
REQ-003 The block SHALL expose parameter CNT_W, default 16, meaning the width of the window counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the op beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an op beat this cycle.
REQ-008 The block SHALL have port in_op, input, 3 bits: 000 NOP, 001 RIGHT, 010 DOWN, 100 LEFT, 011 UP, 111 CLEAR; other codes are treated as NOP.
REQ-009 The block SHALL have port in_data, input, K*DATA_W bits: the new line; element j is in_data[j*DATA_W +: DATA_W].
REQ-010 The block SHALL have port pad_en, input, 1 bit: substitute zeros for in_data on this beat (border padding).
REQ-011 The block SHALL have port win_valid, output, 1 bit: the window holds a complete, unconsumed window.
REQ-012 The block SHALL have port win_ready, input, 1 bit: the PE array consumes the window.
REQ-013 The block SHALL have port win_data, output, K*K*DATA_W bits: element (r,c) at [(r*K+c)*DATA_W +: DATA_W]; r=0 is the top row, c=0 is the left column.
REQ-014 The block SHALL have port win_cnt, output, CNT_W bits: count of consumed windows since reset or CLEAR.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready, with in_ready = !win_valid || win_ready (combinational).
REQ-016 Let the line L[j] be in_data element j, or 0 when pad_en=1.
REQ-017 Accepted RIGHT SHALL update W(r,c) <= W(r,c+1) for c<K-1, and W(r,K-1) <= L[r].
REQ-018 Accepted LEFT SHALL update W(r,c) <= W(r,c-1) for c>0, and W(r,0) <= L[r].
REQ-019 Accepted DOWN SHALL update W(r,c) <= W(r+1,c) for r<K-1, and W(K-1,c) <= L[c].
REQ-020 Accepted UP SHALL update W(r,c) <= W(r-1,c) for r>0, and W(0,c) <= L[c].
REQ-021 Accepted CLEAR SHALL zero all W, set fill_cnt=0, clear win_valid and set win_cnt=0 in one cycle, regardless of win_ready.
REQ-022 Accepted NOP, or a cycle with no accept, SHALL leave W and fill_cnt unchanged.
REQ-023 Internal fill_cnt (0..K) SHALL increment on each accepted shift op (RIGHT/LEFT/DOWN/UP) and saturate at K.
REQ-024 win_valid SHALL be set on the edge of an accepted shift op whose post-update fill_cnt equals K, so each shift after fill yields a new window with 1-cycle latency.
REQ-025 win_valid SHALL clear when win_valid && win_ready and no shift op is accepted in the same cycle; a same-cycle consume plus shift keeps win_valid=1 with the new window.
REQ-026 win_cnt SHALL increment by 1 on every cycle with win_valid && win_ready, wrap modulo 2^CNT_W, and a same-cycle CLEAR SHALL take priority (result 0).
REQ-027 win_data SHALL be registered W and SHALL remain stable while win_valid=1 and win_ready=0.
REQ-028 Accepted NOP with win_valid=1 and win_ready=1 SHALL consume the window (win_valid->0) and SHALL leave W unchanged.
REQ-029 Element arithmetic SHALL be none: data passes bit-exact, signed DATA_W.

Reset
REQ-030 rst_n=0 SHALL asynchronously force all W=0, fill_cnt=0, win_valid=0 and win_cnt=0; in_ready then reads 1.
REQ-031 Reset mid-fill or mid-stall SHALL discard the partial window; the first accepted shift after release counts as fill 1.

Verification
REQ-032 Fill (K=3, DATA_W=8): DOWN rows {1,2,3},{4,5,6},{7,8,9}, win_ready=0 -> win_valid=1 one cycle after third accept; W rows = 1 2 3 / 4 5 6 / 7 8 9; in_ready=0.
REQ-033 Stall then slide: from REQ-032 state, present RIGHT {10,11,12} with win_ready=1 -> accepted; rows = 2 3 10 / 5 6 11 / 8 9 12; win_valid stays 1; win_cnt=1.
REQ-034 Padding: LEFT with pad_en=1, in_data={55,66,77} -> column 0 = 0,0,0; other columns shift right by one.
REQ-035 UP then CLEAR: UP {20,21,22} -> top row 20 21 22; next cycle CLEAR with win_valid=1, win_ready=0 -> all W=0, win_valid=0, win_cnt=0, following two shifts leave win_valid=0.
REQ-036 Async reset: assert rst_n low between edges with win_valid=1 -> win_valid, win_data and win_cnt go to 0 immediately, without waiting for an edge.
REQ-037 Counter wrap with CNT_W=2: 4 consumed windows -> win_cnt sequence 1,2,3,0; an undefined op 101 -> treated as NOP, W unchanged.
